cnn_act_pipe: RTL and testbench
===============================

# cnn_act_pipe

Streaming, multi-lane, pipelined output-nonlinearity unit for the cellular-neural-network datapath. It replaces the single-value combinational saturation stage. It computes y = (|x+1| − |x−1|)/2, a hard clamp to [−1, +1], in signed fixed point with a programmable binary point. Each beat can also select a ReLU-style clamp or a bypass. It sits between the template-convolution accumulator and the state/output buffer, and uses a valid/ready handshake on both sides.

## Interface
- WIDTH, 18: signed sample width per lane, for both input and output.
- FRAC, 8: fraction bits. The fixed-point one is ONE = 1 << FRAC. Legal range is 0 ≤ FRAC ≤ WIDTH−2.
- LANES, 4: samples per beat.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  unit accepts the beat on this edge.
- in_data  in  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH], signed.
- in_mode  in  2  per-beat mode: 00 = clamp to [−ONE, ONE]; 01 = clamp to [0, ONE]; 10 = bypass; 11 = treated as 00.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts.
- out_data  out  LANES*WIDTH  results, with the same lane packing as in_data.
- out_sat  out  LANES  per lane: the result differs from the input, meaning it was clamped.
- clr_stats  in  1  synchronous clear of the statistics counter. Present only with the macro enabled.
- sat_count  out  32  running count of clamped lanes. Present only with the macro enabled.

## Operation
- Mode is captured with the data and travels with the beat. A mode change never affects beats already in flight.
- All arithmetic is exact. Stage 1 computes a = |x + ONE| and b = |x − ONE| at WIDTH+2 bits. Stage 2 computes y = (a − b) >>> 1, truncated back to WIDTH bits.
- The result equals min(max(x, −ONE), ONE) for every input, including −2^(WIDTH−1) → −ONE. There is no wrap.
- Mode 01 takes the stage-2 result and forces negative values to 0.
- Mode 10 outputs x unchanged, and out_sat = 0 for that beat.
- out_sat[i] = 1 iff the mode is not bypass and y_i ≠ x_i.
- Lanes are independent and identical.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_sat = 0, sat_count = 0, all stage valids = 0. in_ready = 1 from the first cycle after reset is released.
- Pipeline: two register stages. Latency is 2 cycles from the accepting edge to the first cycle out_valid is high, provided out_ready is held high.
- Throughput is one beat per cycle with no bubbles while out_ready = 1.
- Stage k loads when it is empty or its content leaves on the same edge. Therefore in_ready = !s1_valid | !s2_valid | out_ready, which is combinational from out_ready.
- While out_valid = 1 and out_ready = 0:
  - out_data, out_sat and out_valid hold stable.
  - At most 2 beats are buffered, after which in_ready = 0.
- Simultaneous accept and emit on one edge is legal and loses no data.
- Order is strictly preserved.
- Asserting rst_n low mid-stream immediately discards all in-flight beats, with no partial output.

## Configuration
- CNN_ACT_STATS_EN defined:
  - clr_stats and sat_count exist.
  - On each edge where out_valid & out_ready, sat_count adds popcount(out_sat).
  - The counter saturates at 2^32 − 1.
  - clr_stats = 1 zeroes the counter. If an emit happens on the same edge, that beat's count is dropped.
- CNN_ACT_STATS_EN undefined:
  - Both ports and the counter are absent.
  - All other behaviour is identical.

## Structure
- Shared package cnn_pkg holds:
  - mode constants (MODE_CLAMP, MODE_RELU, MODE_BYPASS);
  - default WIDTH/FRAC;
  - the lane-slice helper.
- Sub-module cnn_act_lane: one lane's stage-1/stage-2 datapath, with no control logic. It is instantiated LANES times.
- The top level owns the valid/ready control, mode pipeline and statistics.

## Test plan
All scenarios use WIDTH = 18, FRAC = 8, so ONE = 256.
- Clamp mode, lanes {100, 300, −131072, −256}: out {100, 256, −256, −256}, out_sat 0b0110 (bit i = lane i), 2 cycles after accept.
- ReLU mode, lanes {−50, 0, 255, 1000}: out {0, 0, 255, 256}, out_sat 0b1001. Bypass with the same input: out equals the input, out_sat 0.
- Stream 10 beats back-to-back with out_ready = 1: 10 consecutive out_valid cycles, in order, and in_ready never drops.
- With out_ready = 0, send beats A, B, C: A and B are accepted and in_ready falls with C pending. Raise out_ready: A, B, C emerge in order with no duplication.
- Alternate the mode every beat on identical data: each output follows its own beat's mode.
- Assert rst_n low 1 cycle after 2 accepts: no output appears, and out_valid = 0 immediately. With CNN_ACT_STATS_EN, 3 clamp beats each with 2 saturated lanes give sat_count = 6, and clr_stats then returns it to 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN output-nonlinearity datapath:
// mode encodings, default geometry and the lane-slice helper.
package cnn_pkg;

  localparam int DEF_WIDTH = 18;
  localparam int DEF_FRAC  = 8;

  localparam logic [1:0] MODE_CLAMP  = 2'b00;
  localparam logic [1:0] MODE_RELU   = 2'b01;
  localparam logic [1:0] MODE_BYPASS = 2'b10;

  function automatic int lane_lo(
    input int lane,
    input int width
  );
    return lane * width;
  endfunction

endpackage

// File: rtl/cnn_act_lane.sv
// One lane of the activation datapath: |x+1| and |x-1| in stage 1,
// halved difference plus mode select and saturation flag in stage 2.
module cnn_act_lane
  import cnn_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld1,
  input  logic                    ld2,
  input  logic signed [WIDTH-1:0] x,
  input  logic [1:0]              mode,
  output logic signed [WIDTH-1:0] y,
  output logic                    sat
);

  localparam int XW = WIDTH + 2;
  localparam logic signed [XW-1:0] ONE = XW'(1) << FRAC;

  logic signed [XW-1:0]    xe;
  logic signed [XW-1:0]    pe;
  logic signed [XW-1:0]    me;
  logic signed [XW-1:0]    a_q;
  logic signed [XW-1:0]    b_q;
  logic signed [WIDTH-1:0] x_q;
  logic signed [WIDTH-1:0] c;
  logic signed [WIDTH-1:0] r;
  logic                    s;

  assign xe = {{2{x[WIDTH-1]}}, x};
  assign pe = xe + ONE;
  assign me = xe - ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      x_q <= '0;
    end else if (ld1) begin
      a_q <= pe[XW-1] ? -pe : pe;
      b_q <= me[XW-1] ? -me : me;
      x_q <= x;
    end
  end

  // a-b spans [-2*ONE, 2*ONE], so the halved value always fits WIDTH
  assign c = WIDTH'((a_q - b_q) >>> 1);

  always_comb begin
    r = c;
    unique case (1'b1)
      mode == MODE_BYPASS: r = x_q;
      mode == MODE_RELU:   r = c[WIDTH-1] ? '0 : c;
      default:             r = c;
    endcase
  end

  assign s = (mode != MODE_BYPASS) && (r != x_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y   <= '0;
      sat <= 1'b0;
    end else if (ld2) begin
      y   <= r;
      sat <= s;
    end
  end

endmodule

// File: rtl/cnn_act_pipe.sv
// Multi-lane pipelined hard-clamp / ReLU / bypass activation unit.
// Optional saturation counter: define CNN_ACT_STATS_EN.
module cnn_act_pipe
  import cnn_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [1:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_sat
`ifdef CNN_ACT_STATS_EN
  ,
  input  logic                   clr_stats,
  output logic [31:0]            sat_count
`endif
);

  logic       s1_valid;
  logic       s2_valid;
  logic       ld1;
  logic       ld2;
  logic       en1;
  logic       en2;
  logic [1:0] mode_q;

  // a stage may load when empty or when its content leaves this edge
  assign ld2 = !s2_valid || out_ready;
  assign ld1 = !s1_valid || ld2;
  assign en1 = ld1 && in_valid;
  assign en2 = ld2 && s1_valid;

  assign in_ready  = ld1;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      mode_q   <= MODE_CLAMP;
    end else begin
      if (ld1) s1_valid <= in_valid;
      if (ld2) s2_valid <= s1_valid;
      if (en1) mode_q <= (in_mode == 2'b11) ? MODE_CLAMP : in_mode;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    cnn_act_lane #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .ld1   (en1),
      .ld2   (en2),
      .x     (in_data[lane_lo(i, WIDTH) +: WIDTH]),
      .mode  (mode_q),
      .y     (out_data[lane_lo(i, WIDTH) +: WIDTH]),
      .sat   (out_sat[i])
    );
  end

`ifdef CNN_ACT_STATS_EN
  localparam int PW = $clog2(LANES + 1);

  logic [PW-1:0] pop;
  logic [32:0]   sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + PW'(out_sat[i]);
    end
  end

  assign sum = {1'b0, sat_count} + 33'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (clr_stats) begin
      sat_count <= '0;
    end else if (out_valid && out_ready) begin
      sat_count <= sum[32] ? '1 : sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_cnn_act_pipe.sv
// Self-checking bench for cnn_act_pipe against a clamp/ReLU/bypass
// reference model driven by directed and random beats.
module tb_cnn_act_pipe;

  localparam int W  = 18;
  localparam int L  = 4;
  localparam int DW = W * L;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [1:0]    in_mode = 2'b00;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [L-1:0]  out_sat;
`ifdef CNN_ACT_STATS_EN
  logic          clr_stats = 1'b0;
  logic [31:0]   sat_count;
`endif

  cnn_act_pipe #(
    .WIDTH (W),
    .FRAC  (8),
    .LANES (L)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
`ifdef CNN_ACT_STATS_EN
    ,
    .clr_stats (clr_stats),
    .sat_count (sat_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [L-1:0]  s;
  } beat_t;

  beat_t         q[$];
  int            n_chk = 0;
  int            n_pass = 0;
  bit            acc;
  bit            emit;
  logic [DW-1:0] od;
  logic [L-1:0]  os;

  function automatic beat_t model(input logic [DW-1:0] d, input logic [1:0] m);
    beat_t r;
    r = '0;
    for (int i = 0; i < L; i++) begin
      int x;
      int y;
      x = $signed(d[i*W +: W]);
      if (m == 2'd2) y = x;
      else begin
        y = (x > 256) ? 256 : ((x < -256) ? -256 : x);
        if (m == 2'd1 && y < 0) y = 0;
      end
      r.d[i*W +: W] = y[W-1:0];
      r.s[i] = (m != 2'd2) && (y != x);
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] pack(input int a, input int b, input int c, input int e);
    return {e[W-1:0], c[W-1:0], b[W-1:0], a[W-1:0]};
  endfunction

  function automatic int rnd_s();
    int k;
    logic [W-1:0] v;
    k = int'($urandom_range(0, 7));
    v = W'($urandom);
    case (k)
      0: return -131072;
      1: return 131071;
      2: return 256;
      3: return -257;
      4, 5: return int'($urandom_range(0, 1200)) - 600;
      default: return int'($signed(v));
    endcase
  endfunction

  function automatic logic [DW-1:0] rnd_beat();
    return pack(rnd_s(), rnd_s(), rnd_s(), rnd_s());
  endfunction

  // one clock: sample handshake just before the edge, record accepts
  task automatic cyc();
    #1;
    acc  = in_valid && in_ready;
    emit = out_valid && out_ready;
    od   = out_data;
    os   = out_sat;
    if (acc) q.push_back(model(in_data, in_mode));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if (out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", out_valid);
    else n_pass++;
    n_chk++;
    if (out_data !== '0) $display("FAIL rst_data got %h want 0", out_data);
    else n_pass++;
    n_chk++;
    if (out_sat !== '0) $display("FAIL rst_sat got %b want 0", out_sat);
    else n_pass++;
`ifdef CNN_ACT_STATS_EN
    n_chk++;
    if (sat_count !== 32'd0) $display("FAIL rst_cnt got %0d want 0", sat_count);
    else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", in_ready);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_clamp();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = 2'b00;
    in_data   = pack(100, 300, -131072, -256);
    cyc();
    n_chk++;
    if (acc !== 1'b1) $display("FAIL clamp_acc got %b want 1", acc);
    else n_pass++;
    in_valid = 1'b0;
    cyc();
    n_chk++;
    if (emit !== 1'b0) $display("FAIL clamp_early got %b want 0", emit);
    else n_pass++;
    cyc();
    n_chk++;
    if (emit !== 1'b1) $display("FAIL clamp_lat got %b want 1", emit);
    else n_pass++;
    n_chk++;
    if (od !== pack(100, 256, -256, -256))
      $display("FAIL clamp_data got %h want %h", od, pack(100, 256, -256, -256));
    else n_pass++;
    n_chk++;
    if (os !== 4'b0110) $display("FAIL clamp_sat got %b want 0110", os);
    else n_pass++;
    q.delete();
  endtask

  task automatic test_relu_bypass();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = pack(-50, 0, 255, 1000);
    in_mode   = 2'b01;
    cyc();
    in_mode = 2'b10;
    cyc();
    in_valid = 1'b0;
    cyc();
    n_chk++;
    if (emit !== 1'b1 || od !== pack(0, 0, 255, 256) || os !== 4'b1001)
      $display("FAIL relu got v%b %h/%b want %h/1001", emit, od, os, pack(0, 0, 255, 256));
    else n_pass++;
    cyc();
    n_chk++;
    if (emit !== 1'b1 || od !== pack(-50, 0, 255, 1000) || os !== 4'b0000)
      $display("FAIL bypass got v%b %h/%b want %h/0000", emit, od, os, in_data);
    else n_pass++;
    q.delete();
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    int first = -1;
    int last = -1;
    beat_t exp;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && got < 10; c++) begin
      in_valid = (sent < 10);
      in_data  = rnd_beat();
      in_mode  = 2'($urandom_range(0, 3));
      cyc();
      if (sent < 10) begin
        n_chk++;
        if (acc !== 1'b1) $display("FAIL b2b_ready beat %0d got %b want 1", sent, acc);
        else n_pass++;
      end
      if (acc) sent++;
      if (emit) begin
        n_chk++;
        if (q.size() == 0) $display("FAIL b2b_extra got %h want none", od);
        else begin
          exp = q.pop_front();
          if ({od, os} !== exp) $display("FAIL b2b_data got %h/%b want %h/%b", od, os, exp.d, exp.s);
          else n_pass++;
        end
        got++;
        if (first < 0) first = c;
        last = c;
      end
    end
    in_valid = 1'b0;
    n_chk++;
    if (got != 10 || last - first != 9)
      $display("FAIL b2b_count got %0d beats over %0d cycles want 10 over 10", got, last - first + 1);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int got = 0;
    beat_t exp;
    logic [DW-1:0] hold;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b00;
    for (int k = 0; k < 2; k++) begin
      in_data = rnd_beat();
      cyc();
      n_chk++;
      if (acc !== 1'b1) $display("FAIL bp_acc beat %0d got %b want 1", k, acc);
      else n_pass++;
    end
    in_data = rnd_beat();
    cyc();
    hold = od;
    n_chk++;
    if (acc !== 1'b0) $display("FAIL bp_full got %b want 0", acc);
    else n_pass++;
    cyc();
    n_chk++;
    if (acc !== 1'b0 || out_valid !== 1'b1 || od !== hold)
      $display("FAIL bp_hold got a%b v%b %h want a0 v1 %h", acc, out_valid, od, hold);
    else n_pass++;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (acc) in_valid = 1'b0;
      if (emit) begin
        n_chk++;
        if (q.size() == 0) $display("FAIL bp_extra got %h want none", od);
        else begin
          exp = q.pop_front();
          if ({od, os} !== exp) $display("FAIL bp_order got %h want %h", od, exp.d);
          else n_pass++;
        end
        got++;
      end
    end
    n_chk++;
    if (got != 3 || q.size() != 0) $display("FAIL bp_count got %0d want 3", got);
    else n_pass++;
  endtask

  task automatic test_mode_alt();
    int got = 0;
    beat_t exp;
    out_ready = 1'b1;
    in_data   = pack(-600, 131071, -131072, rnd_s());
    for (int c = 0; c < 14; c++) begin
      in_valid = (c < 8);
      in_mode  = 2'(c % 4);
      cyc();
      if (emit) begin
        n_chk++;
        if (q.size() == 0) $display("FAIL alt_extra got %h want none", od);
        else begin
          exp = q.pop_front();
          if ({od, os} !== exp) $display("FAIL alt_mode beat %0d got %h/%b want %h/%b", got, od, os, exp.d, exp.s);
          else n_pass++;
        end
        got++;
      end
    end
    n_chk++;
    if (got != 8) $display("FAIL alt_count got %0d want 8", got);
    else n_pass++;
  endtask

  task automatic test_random();
    beat_t exp;
    for (int c = 0; c < 100; c++) begin
      in_valid  = (c < 90) && ($urandom_range(0, 3) != 0);
      out_ready = (c >= 90) || ($urandom_range(0, 2) != 0);
      in_data   = rnd_beat();
      in_mode   = 2'($urandom_range(0, 3));
      cyc();
      if (emit) begin
        n_chk++;
        if (q.size() == 0) $display("FAIL rnd_extra got %h want none", od);
        else begin
          exp = q.pop_front();
          if ({od, os} !== exp) $display("FAIL rnd_data got %h/%b want %h/%b", od, os, exp.d, exp.s);
          else n_pass++;
        end
      end
    end
    n_chk++;
    if (q.size() != 0) $display("FAIL rnd_drain got %0d left want 0", q.size());
    else n_pass++;
  endtask

  task automatic test_midreset();
    int seen = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = 2'b00;
    in_data   = rnd_beat();
    cyc();
    in_data = rnd_beat();
    cyc();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || out_data !== '0)
      $display("FAIL mr_flush got v%b %h want v0 0", out_valid, out_data);
    else n_pass++;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc();
      if (emit) seen++;
    end
    n_chk++;
    if (seen != 0) $display("FAIL mr_ghost got %0d beats want 0", seen);
    else n_pass++;
  endtask

`ifdef CNN_ACT_STATS_EN
  task automatic test_stats();
    out_ready = 1'b1;
    in_mode   = 2'b00;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 3);
      in_data  = pack(300, -300, 5, -5);
      cyc();
    end
    q.delete();
    n_chk++;
    if (sat_count !== 32'd6) $display("FAIL stats_cnt got %0d want 6", sat_count);
    else n_pass++;
    clr_stats = 1'b1;
    cyc();
    clr_stats = 1'b0;
    n_chk++;
    if (sat_count !== 32'd0) $display("FAIL stats_clr got %0d want 0", sat_count);
    else n_pass++;
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_clamp();
    test_relu_bypass();
    test_back_to_back();
    test_backpressure();
    test_mode_alt();
    test_random();
    test_midreset();
`ifdef CNN_ACT_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
